// File: rtl/ex_pkg.sv
// ex_pkg: shared opcode, state and forwarding encodings for the execute stage.
package ex_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_PASS = 4'd10
  } alu_op_e;
  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } md_op_e;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_e;
  localparam int FWD_RF = 0;
endpackage

// File: rtl/stage_ex_md_if.sv
// stage_ex_md_if: ID/EX-side inputs and EX/MEM-side outputs of the execute stage.
interface stage_ex_md_if import ex_pkg::*; #(parameter int XLEN = 32, parameter int NUM_FWD = 2);
  localparam int FSW = $clog2(NUM_FWD + 1);
  logic                    i_valid;
  logic [XLEN-1:0]         i_pc;
  logic [XLEN-1:0]         i_rs1_val;
  logic [XLEN-1:0]         i_rs2_val;
  logic [XLEN-1:0]         i_imm;
  alu_op_e                 i_alu_op;
  logic [1:0]              i_op_a_sel;
  logic                    i_op_b_sel;
  logic                    i_is_md;
  md_op_e                  i_md_op;
  logic [FSW-1:0]          i_fwd_a_sel;
  logic [FSW-1:0]          i_fwd_b_sel;
  logic [NUM_FWD*XLEN-1:0] i_fwd_data;
  logic                    i_flush;
  logic                    o_stall;
  logic                    o_valid;
  logic [XLEN-1:0]         o_result;
  logic [XLEN-1:0]         o_store_data;
  modport master (
    output i_valid, i_pc, i_rs1_val, i_rs2_val, i_imm, i_alu_op, i_op_a_sel, i_op_b_sel,
           i_is_md, i_md_op, i_fwd_a_sel, i_fwd_b_sel, i_fwd_data, i_flush,
    input  o_stall, o_valid, o_result, o_store_data
  );
  modport slave (
    input  i_valid, i_pc, i_rs1_val, i_rs2_val, i_imm, i_alu_op, i_op_a_sel, i_op_b_sel,
           i_is_md, i_md_op, i_fwd_a_sel, i_fwd_b_sel, i_fwd_data, i_flush,
    output o_stall, o_valid, o_result, o_store_data
  );
endinterface

// File: rtl/alu.sv
// alu: single-cycle integer ALU.
module alu import ex_pkg::*; #(parameter int XLEN = 32) (
  input  alu_op_e         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y
);
  localparam int SW = $clog2(XLEN);
  logic [SW-1:0] sh;
  assign sh = b[SW-1:0];
  always_comb begin
    y = '0;
    case (op)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_SLL:  y = a << sh;
      ALU_SLT:  y = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: y = {{(XLEN-1){1'b0}}, a < b};
      ALU_XOR:  y = a ^ b;
      ALU_SRL:  y = a >> sh;
      ALU_SRA:  y = $signed(a) >>> sh;
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      ALU_PASS: y = b;
      default:  y = '0;
    endcase
  end
endmodule

// File: rtl/md_iter.sv
// md_iter: radix-2 shift-add multiplier / restoring divider on operand magnitudes.
module md_iter import ex_pkg::*; #(parameter int XLEN = 32) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic            last,
  input  md_op_e          op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result
);
  md_op_e            op_q;
  logic              sa_q, sb_q, bz_q;
  logic [XLEN-1:0]   m_q, res_q, am, bm, quo, rem;
  logic [2*XLEN-1:0] p_q, p_d, mul_p, div_p, prod;
  logic [XLEN:0]     mul_sum, div_sh, div_df;
  logic              sa, sb, div_ok;
  assign sa = (op inside {MUL, MULH, MULHSU, DIV, REM}) & a[XLEN-1];
  assign sb = (op inside {MUL, MULH, DIV, REM}) & b[XLEN-1];
  assign am = sa ? -a : a;
  assign bm = sb ? -b : b;
  // mul: upper half accumulates, multiplier shifts out of the low half
  assign mul_sum = {1'b0, p_q[2*XLEN-1:XLEN]} + {1'b0, p_q[0] ? m_q : '0};
  assign mul_p   = {mul_sum, p_q[XLEN-1:1]};
  // div: upper half is the partial remainder, quotient bits shift into the low half
  assign div_sh  = {p_q[2*XLEN-1:XLEN], p_q[XLEN-1]};
  assign div_df  = div_sh - {1'b0, m_q};
  assign div_ok  = ~div_df[XLEN];
  assign div_p   = {div_ok ? div_df[XLEN-1:0] : div_sh[XLEN-1:0], p_q[XLEN-2:0], div_ok};
  assign p_d     = op_q[2] ? div_p : mul_p;
  assign prod    = (sa_q ^ sb_q) ? -p_d : p_d;
  assign quo     = bz_q ? '1 : (sa_q ^ sb_q) ? -p_d[XLEN-1:0] : p_d[XLEN-1:0];
  assign rem     = sa_q ? -p_d[2*XLEN-1:XLEN] : p_d[2*XLEN-1:XLEN];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q  <= MUL;
      sa_q  <= 1'b0;
      sb_q  <= 1'b0;
      bz_q  <= 1'b0;
      m_q   <= '0;
      p_q   <= '0;
      res_q <= '0;
    end else if (load) begin
      op_q <= op;
      sa_q <= sa;
      sb_q <= sb;
      bz_q <= b == '0;
      m_q  <= op[2] ? bm : am;
      p_q  <= {{XLEN{1'b0}}, op[2] ? am : bm};
    end else if (step) begin
      p_q <= p_d;
      if (last)
        res_q <= op_q[2] ? (op_q[1] ? rem : quo) : (op_q == MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
    end
  end
  assign result = res_q;
endmodule

// File: rtl/stage_ex_md.sv
// stage_ex_md: execute stage with operand forwarding, single-cycle ALU and a
// stalling iterative mul/div unit.
module stage_ex_md import ex_pkg::*; #(parameter int XLEN = 32, parameter int NUM_FWD = 2) (
  input  logic         i_clk,
  input  logic         i_reset,
  stage_ex_md_if.slave bus
);
  localparam int FSW = $clog2(NUM_FWD + 1);
  localparam int CW  = $clog2(XLEN + 1);
  function automatic logic [XLEN-1:0] fwd(input logic [FSW-1:0] sel, input logic [XLEN-1:0] rf,
                                          input logic [NUM_FWD*XLEN-1:0] data);
    fwd = rf;
    for (int k = FWD_RF + 1; k <= NUM_FWD; k++)
      if (sel == FSW'(k)) fwd = data[(k-1)*XLEN +: XLEN];
  endfunction
  md_state_e       state_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] rs1_f, rs2_f, op_a, op_b, alu_res, md_res;
  logic            start;
  assign rs1_f = fwd(bus.i_fwd_a_sel, bus.i_rs1_val, bus.i_fwd_data);
  assign rs2_f = fwd(bus.i_fwd_b_sel, bus.i_rs2_val, bus.i_fwd_data);
  assign op_a  = bus.i_op_a_sel == 2'b01 ? bus.i_pc : bus.i_op_a_sel == 2'b10 ? '0 : rs1_f;
  assign op_b  = bus.i_op_b_sel ? bus.i_imm : rs2_f;
  assign start = state_q == IDLE & bus.i_valid & bus.i_is_md & ~bus.i_flush;
  alu #(.XLEN(XLEN)) u_alu (.op(bus.i_alu_op), .a(op_a), .b(op_b), .y(alu_res));
  md_iter #(.XLEN(XLEN)) u_md (
    .clk(i_clk), .rst_n(i_reset), .load(start), .step(state_q == BUSY),
    .last(cnt_q == CW'(1)), .op(bus.i_md_op), .a(rs1_f), .b(rs2_f), .result(md_res)
  );
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else if (bus.i_flush && state_q != IDLE) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q <= BUSY;
          cnt_q   <= CW'(XLEN);
        end
        BUSY: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.o_stall      = start | state_q == BUSY;
  assign bus.o_valid      = ~bus.i_flush & (state_q == DONE | (state_q == IDLE & bus.i_valid & ~bus.i_is_md));
  assign bus.o_result     = state_q == DONE ? md_res : alu_res;
  assign bus.o_store_data = rs2_f;
endmodule

// File: tb/tb_stage_ex_md.sv
// tb_stage_ex_md: randomized scoreboard bench for stage_ex_md against an arithmetic reference model.
module tb_stage_ex_md;
  import ex_pkg::*;
  localparam int XLEN = 32;
  localparam int NF   = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];
  always #5 clk = ~clk;
  stage_ex_md_if #(.XLEN(XLEN), .NUM_FWD(NF)) bus ();
  stage_ex_md #(.XLEN(XLEN), .NUM_FWD(NF)) dut (.i_clk(clk), .i_reset(rst_n), .bus(bus));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_alu(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_SLL:  return a << b[4:0];
      ALU_SLT:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
      ALU_XOR:  return a ^ b;
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return 32'(int'(a) >>> b[4:0]);
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      ALU_PASS: return b;
      default:  return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_md(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'(int'(a));
    longint sb = longint'(int'(b));
    longint ub = longint'({32'd0, b});
    logic [63:0] uu;
    logic ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      MUL:    begin uu = 64'(sa * sb); return uu[31:0]; end
      MULH:   begin uu = 64'(sa * sb); return uu[63:32]; end
      MULHSU: begin uu = 64'(sa * ub); return uu[63:32]; end
      MULHU:  begin uu = {32'd0, a} * {32'd0, b}; return uu[63:32]; end
      DIV:    return b == 0 ? 32'hFFFF_FFFF : ovf ? a : 32'(int'(a) / int'(b));
      DIVU:   return b == 0 ? 32'hFFFF_FFFF : a / b;
      REM:    return b == 0 ? a : ovf ? 32'd0 : 32'(int'(a) % int'(b));
      default: return b == 0 ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  // Hide each operand either in the register file or in a random forwarding slot.
  task automatic place(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] fd = {$urandom, $urandom};
    int sa = $urandom_range(0, 3);
    int sb = $urandom_range(0, 3);
    if (sb == sa && (sa == 1 || sa == 2)) sb = 0;
    bus.i_rs1_val = (sa == 1 || sa == 2) ? $urandom : a;
    bus.i_rs2_val = (sb == 1 || sb == 2) ? $urandom : b;
    if (sa == 1 || sa == 2) fd[(sa-1)*32 +: 32] = a;
    if (sb == 1 || sb == 2) fd[(sb-1)*32 +: 32] = b;
    bus.i_fwd_a_sel = 2'(sa);
    bus.i_fwd_b_sel = 2'(sb);
    bus.i_fwd_data  = fd;
  endtask

  task automatic do_alu(input alu_op_e op, input logic [31:0] a, input logic [31:0] b, input logic fl);
    logic [31:0] pc = $urandom;
    logic [31:0] imm = $urandom;
    int asel = $urandom_range(0, 3);
    logic bsel = 1'($urandom_range(0, 1));
    logic [31:0] opa = asel == 1 ? pc : asel == 2 ? 32'd0 : a;
    place(a, b);
    bus.i_pc = pc; bus.i_imm = imm; bus.i_op_a_sel = 2'(asel); bus.i_op_b_sel = bsel;
    bus.i_alu_op = op; bus.i_is_md = 1'b0; bus.i_valid = 1'b1; bus.i_flush = fl;
    if (!fl) exp_q.push_back(ref_alu(op, opa, bsel ? imm : b));
    @(negedge clk);
    chk("store_data", bus.o_store_data, b);
    chk("alu_stall", 32'(bus.o_stall), 32'd0);
    if (fl) chk("alu_flush_valid", 32'(bus.o_valid), 32'd0);
    @(posedge clk); #1;
    bus.i_valid = 1'b0; bus.i_flush = 1'b0;
  endtask

  task automatic start_md(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
    place(a, b);
    bus.i_md_op = op; bus.i_is_md = 1'b1; bus.i_valid = 1'b1; bus.i_flush = 1'b0;
    bus.i_alu_op = alu_op_e'($urandom_range(0, 10));
  endtask

  task automatic do_md(input md_op_e op, input logic [31:0] a, input logic [31:0] b, input logic churn);
    int stalls = 0;
    logic done = 1'b0;
    start_md(op, a, b);
    exp_q.push_back(ref_md(op, a, b));
    for (int c = 0; c < XLEN + 5 && !done; c++) begin
      @(negedge clk);
      if (bus.o_valid) done = 1'b1;
      else begin
        if (bus.o_stall) stalls++;
        @(posedge clk); #1;
        if (churn) begin
          bus.i_fwd_data = {$urandom, $urandom};
          bus.i_rs1_val = $urandom; bus.i_rs2_val = $urandom;
        end
      end
    end
    chk("md_done_seen", 32'(done), 32'd1);
    chk("md_stall_cycles", 32'(stalls), 32'(XLEN + 1));
    @(posedge clk); #1;
    bus.i_valid = 1'b0; bus.i_is_md = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.o_valid) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_valid: result %h with empty scoreboard at %0t", bus.o_result, $time);
      end else chk("result", bus.o_result, exp_q.pop_front());
    end
  end

  initial begin
    bus.i_valid = 1'b0; bus.i_flush = 1'b0; bus.i_is_md = 1'b0; bus.i_md_op = MUL;
    bus.i_alu_op = ALU_ADD; bus.i_op_a_sel = 2'b00; bus.i_op_b_sel = 1'b0;
    bus.i_fwd_a_sel = '0; bus.i_fwd_b_sel = '0; bus.i_fwd_data = '0;
    bus.i_rs1_val = 32'd5; bus.i_rs2_val = 32'd7; bus.i_pc = '0; bus.i_imm = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_stall", 32'(bus.o_stall), 32'd0);
    chk("reset_valid", 32'(bus.o_valid), 32'd0);
    chk("reset_result", bus.o_result, 32'd12);
    @(posedge clk); #1;
    rst_n = 1'b1;
    // slot0 feeds rs1, slot1 feeds rs2
    bus.i_rs1_val = 32'hDEAD; bus.i_rs2_val = 32'hBEEF;
    bus.i_fwd_a_sel = 2'd1; bus.i_fwd_b_sel = 2'd2; bus.i_fwd_data = {32'h20, 32'h10};
    bus.i_alu_op = ALU_ADD; bus.i_valid = 1'b1;
    exp_q.push_back(32'h30);
    @(negedge clk);
    chk("fwd_valid", 32'(bus.o_valid), 32'd1);
    chk("fwd_stall", 32'(bus.o_stall), 32'd0);
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    do_md(MULH, 32'hFFFF_FFFF, 32'd2, 1'b0);
    do_md(MUL, 32'hFFFF_FFFF, 32'd2, 1'b0);
    do_md(DIVU, 32'd100, 32'd7, 1'b1);
    do_md(REMU, 32'd100, 32'd7, 1'b1);
    do_md(DIV, 32'h1234, 32'd0, 1'b0);
    do_md(REM, 32'h1234, 32'd0, 1'b0);
    do_md(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_md(REM, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    start_md(MUL, 32'd3, 32'd5);
    @(posedge clk); #1;
    repeat (9) @(posedge clk);
    #1;
    bus.i_flush = 1'b1;
    @(negedge clk);
    chk("flush_cycle_stall", 32'(bus.o_stall), 32'd1);
    chk("flush_cycle_valid", 32'(bus.o_valid), 32'd0);
    @(posedge clk); #1;
    bus.i_flush = 1'b0; bus.i_valid = 1'b0; bus.i_is_md = 1'b0;
    @(negedge clk);
    chk("post_flush_stall", 32'(bus.o_stall), 32'd0);
    chk("post_flush_valid", 32'(bus.o_valid), 32'd0);
    @(posedge clk); #1;
    do_alu(ALU_ADD, 32'd40, 32'd2, 1'b0);
    start_md(MULHU, 32'd9, 32'd9);
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0; bus.i_valid = 1'b0; bus.i_is_md = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_stall", 32'(bus.o_stall), 32'd0);
    chk("post_reset_valid", 32'(bus.o_valid), 32'd0);
    @(posedge clk); #1;
    do_md(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 0)
        do_alu(alu_op_e'($urandom_range(0, 10)), pick(), pick(), $urandom_range(0, 4) == 0);
      else
        do_md(md_op_e'($urandom_range(0, 7)), pick(), pick(), 1'($urandom_range(0, 1)));
    end
    repeat (2) @(posedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/stage_ex_md.md
Name: stage_ex_md

Overview:
- Parametrised next-generation execute stage.
- Single-cycle ALU path with operand forwarding from NUM_FWD configurable sources.
- Adds an iterative RV-M multiply/divide unit behind a stall handshake.
- Sits between the ID/EX and EX/MEM pipeline registers. Drives o_stall to the hazard unit while a multi-cycle op is in flight.

Parameters:
- XLEN, 32: datapath width; must be even and >= 8.
- NUM_FWD, 2: number of forwarding sources besides the register file (slot 1 = EX/MEM, slot 2 = WB, ...).
- FSW, $clog2(NUM_FWD+1): forward-select width (derived; not overridable).

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous active-low reset
- i_valid  in  1  instruction in EX is valid
- i_pc  in  XLEN  instruction PC
- i_rs1_val  in  XLEN  rs1 from register file
- i_rs2_val  in  XLEN  rs2 from register file
- i_imm  in  XLEN  immediate
- i_alu_op  in  4  ALU operation (existing alu encoding)
- i_op_a_sel  in  2  00 rs1, 01 pc, 10 zero, 11 rs1
- i_op_b_sel  in  1  0 rs2, 1 imm
- i_is_md  in  1  instruction is mul/div
- i_md_op  in  3  md_op_e (see package)
- i_fwd_a_sel  in  FSW  0 = register file; k = i_fwd_data slice k-1
- i_fwd_b_sel  in  FSW  as i_fwd_a_sel, for rs2
- i_fwd_data  in  NUM_FWD*XLEN  packed forwarding values; slot k at bits [k*XLEN +: XLEN]
- i_flush  in  1  kill instruction in EX
- o_stall  out  1  hold IF/ID/EX; insert bubble into EX/MEM
- o_valid  out  1  o_result valid for EX/MEM this cycle
- o_result  out  XLEN  ALU or mul/div result
- o_store_data  out  XLEN  forwarded rs2

Behaviour:
- Reset (i_reset=0 at a rising edge): FSM to IDLE; md result register, latched operands and counter cleared. Then o_stall=0, o_valid=0, o_result=ALU value (combinational).
- Forwarding: select value > NUM_FWD falls back to register-file value. o_store_data is always forwarded rs2, combinational.
- ALU path, i_is_md=0: zero-latency combinational result through alu. o_valid=i_valid & ~i_flush. o_stall=0.
- FSM states IDLE, BUSY, DONE.
- IDLE:
  - i_valid & i_is_md & ~i_flush: latch forwarded rs1/rs2 and md_op, load counter=XLEN, go BUSY.
  - That same cycle: o_stall=1, o_valid=0.
- BUSY:
  - One iteration per cycle; counter decrements; o_stall=1, o_valid=0.
  - When counter reaches 1, go DONE.
  - Latched operands only are used: forwarding inputs may change while stalled.
- DONE:
  - o_result = md result register; o_valid=1; o_stall=0.
  - Always go IDLE next cycle, so the same instruction is never restarted.
- Latency: accept at cycle T, BUSY T+1..T+XLEN, DONE at T+XLEN+1. Total stall = XLEN+1 cycles.
- Multiply:
  - Radix-2 shift-add on operand magnitudes into a 2*XLEN product, negated at DONE if signs differ.
  - MULHSU treats rs2 as unsigned.
  - MUL returns low XLEN bits; MULH/MULHSU/MULHU return high XLEN bits.
- Divide: restoring, on magnitudes; quotient sign = sign(rs1) xor sign(rs2); remainder sign = sign(rs1).
- Divide by zero: quotient = all ones; remainder = rs1. Full XLEN cycles still taken.
- Signed overflow (rs1 = most-negative, rs2 = -1): DIV returns rs1; REM returns 0.
- i_flush in BUSY or DONE: next state IDLE; o_valid forced 0 that cycle; o_stall drops the cycle after flush.
- Flush has priority over start in IDLE.
- Reset mid-operation: immediate IDLE; partial result discarded.

Decomposition:
- Package ex_pkg:
  - md_op_e: MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7.
  - md_state_e: IDLE, BUSY, DONE.
  - Forward-select constant FWD_RF=0.
- Sub-module md_iter (parametrised by XLEN) owns:
  - magnitude/sign preprocessing;
  - shift-add and restoring iteration registers;
  - special-case and sign fix-up.
- The top level keeps the forwarding muxes, operand muxes, the alu instance and the FSM.

Test Plan:
- ALU forwarding: i_alu_op=ADD, i_fwd_a_sel=1 with slot0=0x10, i_fwd_b_sel=2 with slot1=0x20 -> o_result=0x30, o_valid=1 same cycle, o_stall=0.
- MULH: rs1=0xFFFFFFFF (-1), rs2=0x00000002 -> o_stall high 33 cycles; DONE o_result=0xFFFFFFFF, o_valid=1 for exactly one cycle. MUL on same operands -> 0xFFFFFFFE.
- Operand latching: start DIVU 100/7, then change i_fwd_data every BUSY cycle -> quotient 14; REMU -> 2.
- Divide corners: DIV x/0 with x=0x1234 -> 0xFFFFFFFF, REM -> 0x1234. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
- Flush: i_flush at BUSY cycle 10 -> state IDLE next cycle, o_stall low, no o_valid pulse. A following ADD completes normally.
- Reset: i_reset=0 mid-BUSY -> next cycle o_stall=0, o_valid=0. A subsequent MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
